dmem_responder: RTL and testbench

- Data-memory responder: the memory end of the hart's dmem port, replacing the combinational dmem model with a realistic latency-bearing memory.
- Accepts one word-aligned request at a time (read or masked write) over a valid/ready handshake.
- Performs the access after a fixed, parameterised latency and returns a one-cycle response carrying read data and an error flag.
- Sits between the hart's memory-stage request logic and the backing storage array.

---
 rtl/dmem_responder.sv | 121 ++++++++++++
 tb/tb_dmem_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Latency-bearing data-memory responder: one word-aligned read or masked write at a time,
// answered with a single-cycle response strobe after LATENCY clock edges.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_ren,
    input  logic        i_req_wen,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_mask,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);

    localparam int unsigned IW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        ren_q;
    logic        wen_q;
    logic [3:0]  mask_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] off;
    logic [IW-1:0] idx;
    logic        err_c;
    logic [31:0] lane_mask;
    logic        access;
    logic        do_write;

    // Addresses below BASE_ADDR wrap to large offsets and fall out of range.
    always_comb begin
        off       = addr_q - BASE_ADDR;
        idx       = off[IW+1:2];
        err_c     = (ren_q == wen_q) || (addr_q[1:0] != 2'b00) || ({1'b0, off} >= SPAN);
        lane_mask = '0;
        for (int n = 0; n < 4; n++) begin
            lane_mask[8*n +: 8] = {8{mask_q[n]}};
        end
        access    = (state == BUSY) && (cnt == 4'd0);
        do_write  = access && wen_q && !err_c;
    end

    // Storage array carries no reset.
    always_ff @(posedge i_clk) begin
        if (do_write) begin
            for (int n = 0; n < 4; n++) begin
                if (mask_q[n]) begin
                    mem[idx][8*n +: 8] <= wdata_q[8*n +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ren_q       <= 1'b0;
            wen_q       <= 1'b0;
            mask_q      <= '0;
            o_req_ready <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    o_req_ready <= 1'b1;
                    // Requests are only taken once ready is visible to the requester.
                    if (o_req_ready && i_req_valid) begin
                        addr_q      <= i_req_addr;
                        wdata_q     <= i_req_wdata;
                        ren_q       <= i_req_ren;
                        wen_q       <= i_req_wen;
                        mask_q      <= i_req_mask;
                        cnt         <= 4'(LATENCY - 1);
                        o_req_ready <= 1'b0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (access) begin
                        o_rsp_valid <= 1'b1;
                        o_rsp_err   <= err_c;
                        o_rsp_rdata <= (ren_q && !err_c) ? (mem[idx] & lane_mask) : 32'h0;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    o_rsp_valid <= 1'b0;
                    o_rsp_rdata <= '0;
                    o_rsp_err   <= 1'b0;
                    o_req_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances cover LATENCY=2/BASE=0, LATENCY=3,
// and BASE=0x2000.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [2:0]       valid, ready, ren, wen, rsp_valid, rsp_err;
    logic [2:0][31:0] addr, wdata, rsp_rdata;
    logic [2:0][3:0]  mask;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(valid[0]), .o_req_ready(ready[0]), .i_req_addr(addr[0]),
        .i_req_ren(ren[0]), .i_req_wen(wen[0]), .i_req_wdata(wdata[0]), .i_req_mask(mask[0]),
        .o_rsp_valid(rsp_valid[0]), .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3), .BASE_ADDR(32'h0000_0000)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(valid[1]), .o_req_ready(ready[1]), .i_req_addr(addr[1]),
        .i_req_ren(ren[1]), .i_req_wen(wen[1]), .i_req_wdata(wdata[1]), .i_req_mask(mask[1]),
        .o_rsp_valid(rsp_valid[1]), .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1])
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0000_2000)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(valid[2]), .o_req_ready(ready[2]), .i_req_addr(addr[2]),
        .i_req_ren(ren[2]), .i_req_wen(wen[2]), .i_req_wdata(wdata[2]), .i_req_mask(mask[2]),
        .o_rsp_valid(rsp_valid[2]), .o_rsp_rdata(rsp_rdata[2]), .o_rsp_err(rsp_err[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request on instance d, wait for its response, and check latency/data/err.
    task automatic xact(input int d, input string tag, input logic [31:0] a, input logic r,
                        input logic w, input logic [31:0] wd, input logic [3:0] m,
                        input int exp_lat, input logic [31:0] exp_rd, input logic exp_err);
        int n;
        int lat;
        @(negedge clk);
        addr[d]  = a;
        ren[d]   = r;
        wen[d]   = w;
        wdata[d] = wd;
        mask[d]  = m;
        valid[d] = 1'b1;
        n = 0;
        while (!ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        lat = 999;
        if (ready[d]) begin
            @(posedge clk);
            #1 valid[d] = 1'b0;
            lat = 0;
            while (!rsp_valid[d] && lat < 50) begin
                @(posedge clk);
                #1 lat++;
            end
        end else begin
            valid[d] = 1'b0;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, rsp_rdata[d], exp_rd);
        check({tag, "_err"}, {31'b0, rsp_err[d]}, {31'b0, exp_err});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int ready_cnt;
        int rsp_cnt;
        int pair_bad;
        logic [24:0] rs;
        logic [24:0] rv;

        valid = '0; ren = '0; wen = '0; addr = '0; wdata = '0; mask = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, ready[0]}, 32'h0);
        check("rst_rsp_valid", {31'b0, rsp_valid[0]}, 32'h0);
        check("rst_rdata", rsp_rdata[0], 32'h0);
        check("rst_err", {31'b0, rsp_err[0]}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_pre_edge", {31'b0, ready[0]}, 32'h0);
        @(posedge clk);
        #1 check("ready_post_edge", {31'b0, ready[0]}, 32'h1);

        // Basic write/read and byte lanes
        xact(0, "wr_full", 32'h10, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'hF, 2, 32'h0, 1'b0);
        xact(0, "rd_full", 32'h10, 1'b1, 1'b0, 32'h0, 4'hF, 2, 32'hDEAD_BEEF, 1'b0);
        xact(0, "wr_b3", 32'h10, 1'b0, 1'b1, 32'h5500_0000, 4'b1000, 2, 32'h0, 1'b0);
        xact(0, "rd_b3", 32'h10, 1'b1, 1'b0, 32'h0, 4'hF, 2, 32'h55AD_BEEF, 1'b0);
        xact(0, "rd_hi", 32'h10, 1'b1, 1'b0, 32'h0, 4'b1100, 2, 32'h55AD_0000, 1'b0);
        xact(0, "rd_lo", 32'h10, 1'b1, 1'b0, 32'h0, 4'b0011, 2, 32'h0000_BEEF, 1'b0);

        // Errors
        xact(0, "misalign", 32'h12, 1'b1, 1'b0, 32'h0, 4'hF, 2, 32'h0, 1'b1);
        xact(0, "ren_wen", 32'h10, 1'b1, 1'b1, 32'h1111_1111, 4'hF, 2, 32'h0, 1'b1);
        xact(0, "rd_after_rw", 32'h10, 1'b1, 1'b0, 32'h0, 4'hF, 2, 32'h55AD_BEEF, 1'b0);
        xact(0, "oob", 32'h1000, 1'b1, 1'b0, 32'h0, 4'hF, 2, 32'h0, 1'b1);
        xact(0, "no_op", 32'h10, 1'b0, 1'b0, 32'h0, 4'hF, 2, 32'h0, 1'b1);
        xact(0, "last_word", 32'hFFC, 1'b0, 1'b1, 32'h0BAD_F00D, 4'hF, 2, 32'h0, 1'b0);
        xact(0, "rd_last", 32'hFFC, 1'b1, 1'b0, 32'h0, 4'hF, 2, 32'h0BAD_F00D, 1'b0);

        // Zero mask
        xact(0, "wr_m0", 32'h10, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'h0, 2, 32'h0, 1'b0);
        xact(0, "rd_m0", 32'h10, 1'b1, 1'b0, 32'h0, 4'h0, 2, 32'h0, 1'b0);
        xact(0, "rd_after_m0", 32'h10, 1'b1, 1'b0, 32'h0, 4'hF, 2, 32'h55AD_BEEF, 1'b0);

        // Non-zero base
        xact(2, "b_below", 32'h1FFC, 1'b1, 1'b0, 32'h0, 4'hF, 2, 32'h0, 1'b1);
        xact(2, "b_wr", 32'h2004, 1'b0, 1'b1, 32'hAABB_CCDD, 4'hF, 2, 32'h0, 1'b0);
        xact(2, "b_rd", 32'h2004, 1'b1, 1'b0, 32'h0, 4'b0011, 2, 32'h0000_CCDD, 1'b0);
        xact(2, "b_above", 32'h3000, 1'b1, 1'b0, 32'h0, 4'hF, 2, 32'h0, 1'b1);

        // Back-to-back requests with LATENCY=3 and valid held high
        xact(1, "l3_single", 32'h40, 1'b1, 1'b0, 32'h0, 4'h0, 3, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        addr[1] = 32'h0; ren[1] = 1'b1; wen[1] = 1'b0; mask[1] = 4'h0; valid[1] = 1'b1;
        pair_bad = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            rs[k] = ready[1];
            rv[k] = rsp_valid[1];
            if (rsp_valid[1] && (rsp_err[1] !== 1'b0 || rsp_rdata[1] !== 32'h0)) pair_bad++;
        end
        @(negedge clk);
        valid[1] = 1'b0;
        ready_cnt = 0;
        rsp_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            ready_cnt += int'(rs[k]);
            rsp_cnt += int'(rv[k]);
        end
        for (int k = 0; k < 21; k++) begin
            if (rv[k+4] !== rs[k]) pair_bad++;
        end
        check("l3_ready_count", 32'(ready_cnt), 32'd5);
        check("l3_rsp_count", 32'(rsp_cnt), 32'd5);
        check("l3_rsp_after_accept", 32'(pair_bad), 32'd0);
        repeat (10) @(posedge clk);

        // Reset during an in-flight write
        xact(0, "pre_wr20", 32'h20, 1'b0, 1'b1, 32'h1234_5678, 4'hF, 2, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        check("mid_rst_ready", {31'b0, ready[0]}, 32'h1);
        addr[0] = 32'h20; ren[0] = 1'b0; wen[0] = 1'b1; wdata[0] = 32'hCAFE_F00D;
        mask[0] = 4'hF; valid[0] = 1'b1;
        @(posedge clk);
        #1 valid[0] = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_ready0", {31'b0, ready[0]}, 32'h0);
        check("mid_rst_valid0", {31'b0, rsp_valid[0]}, 32'h0);
        check("mid_rst_rdata0", rsp_rdata[0], 32'h0);
        check("mid_rst_err0", {31'b0, rsp_err[0]}, 32'h0);
        seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1 if (rsp_valid[0]) seen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1 if (rsp_valid[0]) seen++;
        end
        check("mid_rst_no_rsp", 32'(seen), 32'd0);
        xact(0, "post_rst_rd20", 32'h20, 1'b1, 1'b0, 32'h0, 4'hF, 2, 32'h1234_5678, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
